uart_tx: RTL and testbench

Serial UART transmitter peripheral and the transmit-side counterpart of the UART receive path. It serialises one byte per request onto tx_o, LSB first. Each frame is one start bit, 8 data bits, an optional even-parity bit (parity bit = ^data), and one or two stop bits. It sits behind the TX_ADDR_HIGH (8'h06) peripheral slot; the bus-side wrapper drives data/valid and reads busy/done.

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per request onto tx_o, LSB first.
// Frame: start bit, 8 data bits, optional even-parity bit, one or two stop bits.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   baud_div_i   clock cycles per serial bit (0 treated as 1), latched at accept
//   parity_en_i  1: insert even-parity bit after the data bits, latched at accept
//   stopbit_i    0: one stop bit, 1: two stop bits, latched at accept
//   tx_data_i    byte to transmit, latched at accept
//   tx_valid_i   request; accepted on a clock edge while busy_o == 0
//   tx_o         registered serial line, idle high
//   busy_o       frame in progress
//   tx_done_o    one-cycle pulse in the first idle cycle after the last stop bit
module uart_tx #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             parity_en_i,
  input  logic             stopbit_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             tx_done_o
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;

  // div_q is forced to >= 1 at accept, so the subtraction never wraps while busy.
  assign bit_end = (timer_q == (div_q - DIV_W'(1)));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;

    // Bit timer restarts on every bit boundary.
    if (state_q != StIdle) begin
      timer_d = bit_end ? '0 : timer_q + DIV_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        timer_d    = '0;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
        if (tx_valid_i) begin
          state_d  = StStart;
          data_d   = tx_data_i;
          div_d    = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
          par_en_d = parity_en_i;
          stop2_d  = stopbit_i;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d    = par_en_q ? StParity : StStop;
            stop_cnt_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: tx is decoded from the next state so the flop holds the bit
  // that belongs to the cycle being entered.
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_q == StStop) && (state_d == StIdle);
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_q[bit_idx_d];
      StParity: tx_d = ^data_q;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_o      = tx_q;
  assign busy_o    = (state_q != StIdle);
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: each frame is predicted as a list of line levels (one per
// serial bit, each held D cycles) and compared cycle by cycle; a mid-bit
// sampling receiver also decodes the byte back from the line.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div_i = '0;
  logic        parity_en_i = 1'b0;
  logic        stopbit_i = 1'b0;
  logic [7:0]  tx_data_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_o;
  logic        busy_o;
  logic        tx_done_o;

  int n_vec = 0;
  int n_err = 0;

  uart_tx #(.DIV_W(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .baud_div_i  (baud_div_i),
    .parity_en_i (parity_en_i),
    .stopbit_i   (stopbit_i),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .tx_done_o   (tx_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // tx_done_o cycle so a caller may chain the next request there.
  task automatic run_frame(input logic [7:0] data, input logic [15:0] div,
                           input logic par, input logic stop, input bit disturb);
    logic   exp_bits[$];
    logic   rx_bits[$];
    logic [7:0] rx_byte;
    int     d;
    int     len;
    d = (div == 16'd0) ? 1 : int'(div);
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(data[k]);
    if (par) exp_bits.push_back(^data);
    exp_bits.push_back(1'b1);
    if (stop) exp_bits.push_back(1'b1);
    len = d * exp_bits.size();

    tx_data_i   = data;
    baud_div_i  = div;
    parity_en_i = par;
    stopbit_i   = stop;
    tx_valid_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid_i = 1'b0;

    for (int i = 0; i < len; i++) begin
      if (disturb && i == len / 2) begin
        tx_valid_i  = 1'b1;
        tx_data_i   = 8'h3C;
        baud_div_i  = div + 16'd7;
        parity_en_i = ~par;
        stopbit_i   = ~stop;
      end
      if (disturb && i == len / 2 + 1) tx_valid_i = 1'b0;
      chk("frame", {29'd0, tx_o, busy_o, tx_done_o}, {29'd0, exp_bits[i / d], 1'b1, 1'b0});
      if (i % d == d / 2) rx_bits.push_back(tx_o);
      @(negedge clk);
    end
    chk("done_pulse", {29'd0, tx_o, busy_o, tx_done_o}, 32'b101);

    for (int k = 0; k < 8; k++) rx_byte[k] = rx_bits[k + 1];
    chk("rx_start", {31'd0, rx_bits[0]}, 32'd0);
    chk("rx_byte", {24'd0, rx_byte}, {24'd0, data});
    if (par) chk("rx_parity", {31'd0, rx_bits[9]}, {31'd0, ^data});
    chk("rx_stop", {31'd0, rx_bits[rx_bits.size() - 1]}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", {29'd0, tx_o, busy_o, tx_done_o}, 32'b100);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset", {29'd0, tx_o, busy_o, tx_done_o}, 32'b100);
    rst_n = 1'b1;
    idle(2);

    // 8'hA5, D=4, parity, two stop bits: 48-cycle frame
    run_frame(8'hA5, 16'd4, 1'b1, 1'b1, 1'b0);
    idle(2);
    // 8'h07, D=3, parity, one stop bit: 33 cycles
    run_frame(8'h07, 16'd3, 1'b1, 1'b0, 1'b0);
    idle(1);
    // Back-to-back: second request on the done cycle
    run_frame(8'h00, 16'd2, 1'b0, 1'b0, 1'b0);
    run_frame(8'hFF, 16'd2, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Mid-frame request and config changes are ignored
    run_frame(8'h55, 16'd3, 1'b0, 1'b1, 1'b1);
    idle(4);
    // Divider 0 behaves like 1
    run_frame(8'h96, 16'd0, 1'b1, 1'b1, 1'b0);
    idle(1);
    run_frame(8'h96, 16'd1, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Asynchronous reset during DATA
    tx_data_i  = 8'hC3;
    baud_div_i = 16'd4;
    parity_en_i = 1'b0;
    stopbit_i  = 1'b0;
    tx_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {29'd0, tx_o, busy_o, tx_done_o}, 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // Loopback-style frames at 115200 baud from 10 MHz
    run_frame(8'h00, 16'd87, 1'b1, 1'b1, 1'b0);
    run_frame(8'h55, 16'd87, 1'b1, 1'b1, 1'b0);
    run_frame(8'hAA, 16'd87, 1'b1, 1'b1, 1'b0);
    run_frame(8'hFF, 16'd87, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Random frames, sometimes chained, sometimes with idle gaps
    for (int k = 0; k < 24; k++) begin
      run_frame(8'($urandom), 16'($urandom_range(0, 5)), 1'($urandom),
                1'($urandom), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
